interlink_pipe: RTL and testbench



---
 rtl/interlink_pkg.sv | 14 +
 rtl/interlink_stage.sv | 87 ++++++++
 rtl/interlink_pipe.sv | 87 ++++++++
 tb/tb_interlink_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interlink_pkg.sv
// Shared types for the interlink prefix-reduction pipe.
package interlink_pkg;

  localparam int unsigned IL_MODE_W = 2;

  // Per-beat reduction operator applied across lanes
  typedef enum logic [IL_MODE_W-1:0] {
    IL_AND  = 2'b00,
    IL_OR   = 2'b01,
    IL_XOR  = 2'b10,
    IL_PASS = 2'b11
  } il_mode_e;

endpackage

// File: rtl/interlink_stage.sv
// One pipe stage: valid/data/mode register plus the lane-prefix reduction
// of its incoming data. BYPASS=1 registers the input unchanged (stage 0).
// Optional macro INTERLINK_PARITY_EN adds a registered parity of the stored data.
module interlink_stage
  import interlink_pkg::*;
#(
  parameter int unsigned LANES  = 3,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [LANES-1:0] i_data,
  input  il_mode_e         i_mode,
  output logic             o_valid,
  output logic [LANES-1:0] o_data,
`ifdef INTERLINK_PARITY_EN
  output logic             o_par,
`endif
  output il_mode_e         o_mode
);

  logic [LANES-1:0] w_next;
  logic             w_acc;
  logic             r_valid;
  logic [LANES-1:0] r_data;
  il_mode_e         r_mode;

  if (BYPASS) begin : g_bypass
    // Stage 0 stores the producer vector unmodified
    always_comb begin
      w_acc  = 1'b0;
      w_next = i_data;
    end
  end else begin : g_prefix
    // Running lane-prefix: p[0]=q[0], p[i]=p[i-1] op q[i]; PASS keeps q
    always_comb begin
      w_next = i_data;
      w_acc  = i_data[0];
      for (int i = 1; i < int'(LANES); i++) begin
        case (i_mode)
          IL_AND:  w_acc = w_acc & i_data[i];
          IL_OR:   w_acc = w_acc | i_data[i];
          IL_XOR:  w_acc = w_acc ^ i_data[i];
          default: w_acc = i_data[i];
        endcase
        w_next[i] = w_acc;
      end
    end
  end

  // Valid follows the upstream slot on every load; payload only moves with a real beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= IL_AND;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_next;
        r_mode <= i_mode;
      end
    end
  end

`ifdef INTERLINK_PARITY_EN
  logic r_par;

  // Parity captured on the same edge as the payload it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (i_load && i_valid) begin
      r_par <= ^w_next;
    end
  end

  assign o_par = r_par;
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;

endmodule

// File: rtl/interlink_pipe.sv
// Configurable-latency prefix-reduction pipe with valid/ready handshake and
// per-stage bubble collapsing. Optional macro INTERLINK_PARITY_EN adds out_par.
module interlink_pipe
  import interlink_pkg::*;
#(
  parameter int unsigned LANES  = 3,
  parameter int unsigned STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES-1:0]     in_data,
  input  logic [IL_MODE_W-1:0] in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     out_data,
  output logic [IL_MODE_W-1:0] out_mode,
`ifdef INTERLINK_PARITY_EN
  output logic                 out_par,
`endif
  output logic                 busy
);

  logic [STAGES:0]   w_ready;
  logic [STAGES-1:0] w_v;
  logic [LANES-1:0]  w_d [STAGES];
  il_mode_e          w_m [STAGES];
`ifdef INTERLINK_PARITY_EN
  logic              w_par [STAGES];
`endif

  assign w_ready[STAGES] = out_ready;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    // A stage may load when it is empty or the stage after it is moving
    assign w_ready[k] = ~w_v[k] | w_ready[k+1];

    if (k == 0) begin : g_first
      interlink_stage #(
        .LANES  (LANES),
        .BYPASS (1'b1)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ready[k]),
        .i_valid (in_valid),
        .i_data  (in_data),
        .i_mode  (il_mode_e'(in_mode)),
        .o_valid (w_v[k]),
        .o_data  (w_d[k]),
`ifdef INTERLINK_PARITY_EN
        .o_par   (w_par[k]),
`endif
        .o_mode  (w_m[k])
      );
    end else begin : g_next
      interlink_stage #(
        .LANES  (LANES),
        .BYPASS (1'b0)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ready[k]),
        .i_valid (w_v[k-1]),
        .i_data  (w_d[k-1]),
        .i_mode  (w_m[k-1]),
        .o_valid (w_v[k]),
        .o_data  (w_d[k]),
`ifdef INTERLINK_PARITY_EN
        .o_par   (w_par[k]),
`endif
        .o_mode  (w_m[k])
      );
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_v[STAGES-1];
  assign out_data  = w_d[STAGES-1];
  assign out_mode  = IL_MODE_W'(w_m[STAGES-1]);
  assign busy      = |w_v;
`ifdef INTERLINK_PARITY_EN
  assign out_par   = w_par[STAGES-1];
`endif

endmodule

// File: tb/tb_interlink_pipe.sv
// Scoreboard bench for interlink_pipe; model computes prefixes from lane masks.
module tb_interlink_pipe;

  localparam int unsigned LANES  = 3;
  localparam int unsigned STAGES = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_data;
  logic [1:0]       out_mode;
  logic             busy;
`ifdef INTERLINK_PARITY_EN
  logic             out_par;
`endif

  interlink_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
`ifdef INTERLINK_PARITY_EN
    .out_par   (out_par),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] d;
    logic [1:0]       m;
    int               cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_stall = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Prefix from the definition: AND = all lower lanes set, OR = any set, XOR = odd count
  function automatic logic [LANES-1:0] pfx(input logic [LANES-1:0] q, input logic [1:0] op);
    logic [LANES-1:0] p;
    int unsigned      ones;
    p = q;
    if (op != 2'b11) begin
      for (int i = 0; i < int'(LANES); i++) begin
        ones = $countones(q & LANES'((64'd1 << (i + 1)) - 64'd1));
        case (op)
          2'b00:   p[i] = (ones == 32'(i + 1));
          2'b01:   p[i] = (ones != 0);
          default: p[i] = ones[0];
        endcase
      end
    end
    return p;
  endfunction

  function automatic logic [LANES-1:0] model(input logic [LANES-1:0] q, input logic [1:0] op);
    logic [LANES-1:0] r;
    r = q;
    for (int s = 1; s < int'(STAGES); s++) r = pfx(r, op);
    return r;
  endfunction

  // Drive one cycle; accepted beats go to the scoreboard with their accept cycle
  task automatic step(input logic v, input logic [LANES-1:0] d, input logic [1:0] m,
                      input logic rdy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = rdy;
    #1;
    if (!out_ready) last_stall = cyc;
    acc = in_valid && in_ready;
    if (acc) begin
      e.d   = model(d, m);
      e.m   = m;
      e.cyc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 60 && sbq.size() != 0; i++) step(1'b0, '0, 2'b00, 1'b1, a);
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still expected", sbq.size());
      sbq.delete();
    end
    step(1'b0, '0, 2'b00, 1'b1, a);
  endtask

  // Monitor: pops on every output handshake and checks hold stability under stall
  initial begin
    int               prev_hold;
    logic [LANES-1:0] prev_d;
    logic [1:0]       prev_m;
    exp_t             e;
    prev_hold = 0;
    prev_d    = '0;
    prev_m    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_hold = 0;
        continue;
      end
      if (prev_hold != 0) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_d));
        chk("hold_mode", 32'(out_mode), 32'(prev_m));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h with empty scoreboard", out_data);
        end else begin
          e = sbq.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_mode", 32'(out_mode), 32'(e.m));
`ifdef INTERLINK_PARITY_EN
          chk("out_par", 32'(out_par), 32'(^e.d));
`endif
          if (e.cyc > last_stall) chk("latency", 32'(cyc - e.cyc), 32'(STAGES));
        end
      end
      prev_hold = (out_valid && !out_ready) ? 1 : 0;
      prev_d    = out_data;
      prev_m    = out_mode;
    end
  end

  initial begin
    logic a;
    int   nacc;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Directed vectors
    step(1'b1, LANES'(3'b111), 2'b00, 1'b1, a);
    step(1'b1, LANES'(3'b101), 2'b00, 1'b1, a);
    step(1'b1, LANES'(3'b110), 2'b10, 1'b1, a);
    step(1'b1, LANES'(3'b010), 2'b01, 1'b1, a);
    step(1'b1, LANES'(3'b100), 2'b11, 1'b1, a);
    step(1'b1, LANES'(3'b001), 2'b01, 1'b1, a);
    drain();

    // Back-to-back beats, exact latency implies no gaps
    for (int i = 0; i < 6; i++) step(1'b1, LANES'($urandom), 2'($urandom), 1'b1, a);
    drain();

    // Stall: exactly STAGES beats absorbed
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, LANES'($urandom), 2'($urandom), 1'b0, a);
      if (a) nacc++;
    end
    chk("stall_accepts", 32'(nacc), 32'(STAGES));
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    drain();

    // Bubble collapse: beat, two idles, two more beats, all with out_ready low
    step(1'b1, LANES'($urandom), 2'($urandom), 1'b0, a);
    chk("bubble_acc0", 32'(a), 32'd1);
    step(1'b0, '0, 2'b00, 1'b0, a);
    step(1'b0, '0, 2'b00, 1'b0, a);
    step(1'b1, LANES'($urandom), 2'($urandom), 1'b0, a);
    chk("bubble_acc1", 32'(a), 32'd1);
    step(1'b1, LANES'($urandom), 2'($urandom), 1'b0, a);
    chk("bubble_acc2", 32'(a), 32'd1);
    @(posedge clk);
    #1;
    chk("bubble_full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, LANES'($urandom), 2'($urandom), 1'b0, a);
    chk("bubble_reject", 32'(a), 32'd0);
    drain();

    // Reset with beats in flight
    step(1'b1, LANES'(3'b111), 2'b01, 1'b0, a);
    step(1'b1, LANES'(3'b011), 2'b10, 1'b0, a);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, '0, 2'b00, 1'b1, a);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), LANES'($urandom), 2'($urandom),
           1'($urandom_range(0, 2) != 0), a);
    drain();
    chk("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
